// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit sequencer for an 11-bit UART frame shift register.
// It latches a byte and its framing on an accepted write and builds the start,
// data, parity and stop fields. It then issues one load strobe followed by
// eleven baud-paced shift strobes, and reports ready and overrun status.
//
// Host handshake: write is a single-cycle request. It is accepted only when
// tx_rdy = 1 in that cycle. A write presented while tx_rdy = 0 is dropped and
// raises the sticky tx_ovr flag. tx_rdy falls in the cycle after acceptance
// and rises again in the cycle after the 11th shift strobe.
module uart_tx_ctrl #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [7:0]       tx_data,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             clr_ovr,
  output logic             ld,
  output logic             sh,
  output logic             bit_10,
  output logic             bit_9,
  output logic             bit_1,
  output logic             bit_0,
  output logic [6:0]       LData,
  output logic             tx_rdy,
  output logic             tx_ovr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      frame_q, frame_d;
  logic             ld_q, ld_d;
  logic             sh_q, sh_d;
  logic             rdy_q, rdy_d;
  logic             ovr_q, ovr_d;

  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_last;
  logic             par_bit;
  logic [10:0]      frame_new;

  // Effective divisor: anything below 2 runs as 2 cycles per bit.
  always_comb begin
    div_eff  = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
    div_last = div_eff - DIV_W'(1);
  end

  // Frame built from the write-cycle inputs; bit 0 leaves the register first.
  always_comb begin
    par_bit   = (eight ? (^tx_data) : (^tx_data[6:0])) ^ ohel;
    frame_new = '1;
    frame_new[0]   = 1'b0;
    frame_new[1]   = tx_data[0];
    frame_new[7:2] = tx_data[6:1];
    if (eight) begin
      frame_new[8] = tx_data[7];
      frame_new[9] = pen ? par_bit : 1'b1;
    end else begin
      frame_new[8] = pen ? par_bit : 1'b1;
      frame_new[9] = 1'b1;
    end
    frame_new[10] = 1'b1;
  end

  // Next-state logic for the sequencer, counters, latched frame and status.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    frame_d    = frame_q;
    case (state_q)
      S_IDLE: begin
        if (write) begin
          state_d = S_LOAD;
          div_d   = baud_div;
          frame_d = frame_new;
        end
      end
      S_LOAD: begin
        state_d    = S_SHIFT;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
      end
      S_SHIFT: begin
        if (baud_cnt_q == div_last) begin
          baud_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd10) begin
            state_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes and ready are registered, so they are derived from next state.
    ld_d  = (state_d == S_LOAD);
    sh_d  = (state_d == S_SHIFT) && (baud_cnt_d == div_last);
    rdy_d = (state_d == S_IDLE);

    // A busy write sets overrun; setting takes priority over clearing.
    ovr_d = ovr_q;
    if (write && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  // State register; the frame resets to all-mark so a stray load sends idle line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      div_q      <= '0;
      frame_q    <= '1;
      ld_q       <= 1'b0;
      sh_q       <= 1'b0;
      rdy_q      <= 1'b1;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      frame_q    <= frame_d;
      ld_q       <= ld_d;
      sh_q       <= sh_d;
      rdy_q      <= rdy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ld     = ld_q;
  assign sh     = sh_q;
  assign tx_rdy = rdy_q;
  assign tx_ovr = ovr_q;
  assign bit_0  = frame_q[0];
  assign bit_1  = frame_q[1];
  assign LData  = frame_q[8:2];
  assign bit_9  = frame_q[9];
  assign bit_10 = frame_q[10];

endmodule
